mem_write_checker: RTL and testbench
====================================

// Module: mem_write_checker
// PURPOSE
//  Parametrised self-checking bench monitor on the CPU data-memory write bus. Arms on a start
//  write, compares up to NUM_CHK programmed (addr,data) expectations against subsequent writes,
//  counts errors and cycles, and reports finish/pass, with timeout and ordered/unordered modes.
//  Sits in the TestBed beside the DUT; the DUT is unaware of it.
// PARAMETERS
//  AW          30          word-address width of the monitored bus
//  DW          32          data width
//  NUM_CHK     8           expectation table depth (1..16)
//  START_ADDR  30'h0       address of the arming write
//  START_DATA  32'h5       data value of the arming write
//  TIMEOUT     16'hFFFF    max cycles spent in CHECK before forced report
//  ORDERED     0           0: any order; 1: writes must arrive in table-index order
// PORTS
//  clk        in   1              clock
//  rst        in   1              asynchronous, active-low reset
//  addr       in   AW             monitored write address
//  data       in   DW             monitored write data
//  wen        in   1              monitored write enable (held high across D-cache stalls)
//  cfg_we     in   1              table write strobe (honoured in IDLE only)
//  cfg_idx    in   $clog2(NUM_CHK) table entry index
//  cfg_addr   in   AW             expected address for entry
//  cfg_data   in   DW             expected data for entry
//  error_num  out  8              error count; 8'hFF = not armed
//  duration   out  16             cycles spent in CHECK
//  checked    out  $clog2(NUM_CHK+1) entries resolved so far
//  finish     out  1              high while in REPORT
//  timed_out  out  1              REPORT reached via TIMEOUT
// BEHAVIOUR
//  Reset: state IDLE, error_num 8'hFF, duration 0, checked 0, finish 0, timed_out 0,
//   all entry valid/hit bits 0, busy 0.
//  Write accept: accepted write = wen && !busy (same cycle); busy<=1 on accept, busy<=0 when
//   !wen. A stalled write held N cycles counts once. busy updates in every state.
//  Table: cfg_we in IDLE writes entry[cfg_idx] and sets valid; out-of-range idx ignored.
//   Enabled entry count E = number of valid entries; E=0 -> REPORT immediately after arming.
//  IDLE: duration 0, error_num 8'hFF. Accepted write with addr==START_ADDR && data==START_DATA
//   -> CHECK, error_num<=0. Other writes ignored.
//  CHECK: duration +1 per cycle, saturating at 16'hFFFF. On accepted write:
//   unordered: lowest valid entry with matching addr and hit=0 -> set hit, checked+1,
//    error+1 if data differs; addr matches only hit entries -> error+1 (duplicate);
//    no address match -> ignored.
//   ordered: addr matches any valid entry -> compare against entry[ptr] (addr and data);
//    mismatch -> error+1; ptr+1, checked+1 either way; non-table addr ignored.
//   error_num saturates at 8'hFE (8'hFF reserved).
//   checked==E (registered) -> REPORT next cycle; final write thus seen 2 cycles before finish.
//   duration==TIMEOUT-1 and checked<E -> REPORT, timed_out<=1, error_num += (E-checked), sat.
//   Completion and timeout on the same cycle: completion wins, timed_out=0.
//  REPORT: finish=1 (registered); all counters frozen; only reset leaves.
//  Start write while in CHECK: normal write (ignored unless it is a table address).
//  Reset mid-operation: immediate return to reset values, table cleared.
//  Simulation-only $display of each mismatch (addr, data, expected) and pass/fail banner on
//   negedge in REPORT, guarded by `ifndef SYNTHESIS.
// STRUCTURE
//  Package chk_pkg: state enum {IDLE,CHECK,REPORT}, ERR_UNARMED=8'hFF, ERR_MAX=8'hFE.
//  Sub-module wr_accept (busy flop + accept pulse), reused by other bus monitors.
//  Table as flop arrays with per-entry valid/hit; match via priority encoder; single FSM.
// TESTING
//  T1 E=3 {1:4,2:4,3:4}, start (0,5), writes 1/2/3 data 4 -> finish, error_num 0, timed_out 0.
//  T2 same table, write 2 data 7 -> error_num 1; wen held 5 cycles on one write -> counted once.
//  T3 unordered, writes 3,1,1,2 all data 4 -> error_num 1 (duplicate), checked 3, finish.
//  T4 ORDERED=1, writes 2,1,3 data 4 -> error_num 2, finish.
//  T5 TIMEOUT=20, only write 1 -> finish at duration 19, timed_out 1, error_num 2.
//  T6 start write (0,6) ignored; rst low mid-CHECK -> error_num 8'hFF, table cleared.

Source files
------------

// File: rtl/chk_pkg.sv
// rtl/chk_pkg.sv - shared types and constants for the memory write checker
package chk_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CHECK  = 2'd1,
    REPORT = 2'd2
  } state_t;

  localparam logic [7:0] ERR_UNARMED = 8'hFF;
  localparam logic [7:0] ERR_MAX     = 8'hFE;

  // 8'hFF is reserved for "not armed", so error counts clamp one below it
  function automatic logic [7:0] err_add(input logic [7:0] err, input logic [7:0] inc);
    logic [8:0] sum;
    sum = {1'b0, err} + {1'b0, inc};
    return (sum > {1'b0, ERR_MAX}) ? ERR_MAX : sum[7:0];
  endfunction

endpackage

// File: rtl/mem_write_checker_wr_accept.sv
// rtl/mem_write_checker_wr_accept.sv - one accept pulse per write, however long wen is held
module wr_accept (
  input  logic clk,
  input  logic rst,
  input  logic wen,
  output logic accept
);

  logic busy;

  // busy follows wen: set by the accepted cycle, held through stalls, cleared when wen drops
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy <= 1'b0;
    end else begin
      busy <= wen;
    end
  end

  assign accept = wen && !busy;

endmodule

// File: rtl/mem_write_checker.sv
// rtl/mem_write_checker.sv - data-memory write bus monitor with an expectation table
module mem_write_checker
  import chk_pkg::*;
#(
  parameter int              AW         = 30,
  parameter int              DW         = 32,
  parameter int              NUM_CHK    = 8,
  parameter logic [AW-1:0]   START_ADDR = '0,
  parameter logic [DW-1:0]   START_DATA = DW'(5),
  parameter logic [15:0]     TIMEOUT    = 16'hFFFF,
  parameter bit              ORDERED    = 1'b0,
  localparam int             IW         = (NUM_CHK > 1) ? $clog2(NUM_CHK) : 1,
  localparam int             CW         = $clog2(NUM_CHK + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] data,
  input  logic          wen,
  input  logic          cfg_we,
  input  logic [IW-1:0] cfg_idx,
  input  logic [AW-1:0] cfg_addr,
  input  logic [DW-1:0] cfg_data,
  output logic [7:0]    error_num,
  output logic [15:0]   duration,
  output logic [CW-1:0] checked,
  output logic          finish,
  output logic          timed_out
);

  state_t               state;
  logic                 accept;
  logic [AW-1:0]        tbl_addr [NUM_CHK];
  logic [DW-1:0]        tbl_data [NUM_CHK];
  logic [NUM_CHK-1:0]   tbl_valid;
  logic [NUM_CHK-1:0]   tbl_hit;

  logic [CW-1:0]        num_en;
  logic [CW-1:0]        ord_seen;
  logic                 addr_any;
  logic                 free_found;
  logic [IW-1:0]        free_idx;
  logic                 ord_found;
  logic [IW-1:0]        ord_idx;
  logic                 wr_resolve;
  logic                 wr_err;
  logic [DW-1:0]        exp_data;
  logic                 complete;
  logic                 expire;

  wr_accept u_wr_accept (
    .clk    (clk),
    .rst    (rst),
    .wen    (wen),
    .accept (accept)
  );

  // Priority encoders: lowest unresolved matching entry, and the checked-th valid entry
  always_comb begin
    ord_seen   = '0;
    addr_any   = 1'b0;
    free_found = 1'b0;
    free_idx   = '0;
    ord_found  = 1'b0;
    ord_idx    = '0;
    for (int i = 0; i < NUM_CHK; i++) begin
      if (tbl_valid[i] && tbl_addr[i] == addr) begin
        addr_any = 1'b1;
        if (!tbl_hit[i] && !free_found) begin
          free_found = 1'b1;
          free_idx   = IW'(i);
        end
      end
      if (tbl_valid[i]) begin
        if (!ord_found && ord_seen == checked) begin
          ord_found = 1'b1;
          ord_idx   = IW'(i);
        end
        ord_seen = ord_seen + CW'(1);
      end
    end
    num_en = ord_seen;
  end

  always_comb begin
    wr_resolve = 1'b0;
    wr_err     = 1'b0;
    exp_data   = '0;
    if (ORDERED) begin
      exp_data   = tbl_data[ord_idx];
      wr_resolve = accept && addr_any && ord_found;
      wr_err     = wr_resolve &&
                   (tbl_addr[ord_idx] != addr || tbl_data[ord_idx] != data);
    end else begin
      exp_data   = tbl_data[free_idx];
      wr_resolve = accept && free_found;
      wr_err     = accept && addr_any && (!free_found || tbl_data[free_idx] != data);
    end
  end

  assign complete = (checked == num_en);
  assign expire   = (duration == TIMEOUT - 16'd1);

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CHK; i++) begin
      if (state == IDLE && cfg_we && cfg_idx == IW'(i)) begin
        tbl_addr[i] <= cfg_addr;
        tbl_data[i] <= cfg_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      error_num <= ERR_UNARMED;
      duration  <= '0;
      checked   <= '0;
      finish    <= 1'b0;
      timed_out <= 1'b0;
      tbl_valid <= '0;
      tbl_hit   <= '0;
    end else begin
      case (state)
        IDLE: begin
          for (int i = 0; i < NUM_CHK; i++) begin
            if (cfg_we && cfg_idx == IW'(i)) tbl_valid[i] <= 1'b1;
          end
          if (accept && addr == START_ADDR && data == START_DATA) begin
            state     <= CHECK;
            error_num <= '0;
          end
        end
        CHECK: begin
          // Completion is tested first so it wins over a coincident timeout
          if (complete) begin
            state  <= REPORT;
            finish <= 1'b1;
          end else if (expire) begin
            state     <= REPORT;
            finish    <= 1'b1;
            timed_out <= 1'b1;
            error_num <= err_add(error_num, 8'(num_en - checked));
          end else begin
            if (duration != 16'hFFFF) duration <= duration + 16'd1;
            if (wr_resolve) begin
              checked <= checked + CW'(1);
              if (!ORDERED) tbl_hit[free_idx] <= 1'b1;
            end
            if (wr_err) error_num <= err_add(error_num, 8'd1);
          end
        end
        default: begin
        end
      endcase
    end
  end

`ifndef SYNTHESIS
  logic banner_done;
  always @(negedge clk) begin
    if (state == CHECK && !complete && !expire && wr_err)
      $display("mem_write_checker: write addr=%h data=%h expected=%h", addr, data, exp_data);
    if (state == REPORT && !banner_done)
      $display("mem_write_checker: report errors=%0d checked=%0d timed_out=%0d status=%s",
               error_num, checked, timed_out, (error_num == 8'd0) ? "pass" : "errors");
    banner_done <= (state == REPORT);
  end
`endif

endmodule

// File: tb/tb_mem_write_checker.sv
// tb/tb_mem_write_checker.sv - scoreboard bench for mem_write_checker, unordered and ordered
module tb_mem_write_checker;

  localparam int          AW = 30;
  localparam int          DW = 32;
  localparam int          NC = 8;
  localparam logic [15:0] TO = 16'd32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] data = '0;
  logic          wen = 1'b0;
  logic          cfg_we = 1'b0;
  logic [2:0]    cfg_idx = '0;
  logic [AW-1:0] cfg_addr = '0;
  logic [DW-1:0] cfg_data = '0;

  logic [7:0]  err_u, err_o;
  logic [15:0] dur_u, dur_o;
  logic [3:0]  chk_u, chk_o;
  logic        fin_u, fin_o, to_u, to_o;

  always #5 clk = ~clk;

  mem_write_checker #(.AW(AW), .DW(DW), .NUM_CHK(NC), .TIMEOUT(TO), .ORDERED(1'b0)) dut_u (
    .clk(clk), .rst(rst), .addr(addr), .data(data), .wen(wen),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .error_num(err_u), .duration(dur_u), .checked(chk_u), .finish(fin_u), .timed_out(to_u));

  mem_write_checker #(.AW(AW), .DW(DW), .NUM_CHK(NC), .TIMEOUT(TO), .ORDERED(1'b1)) dut_o (
    .clk(clk), .rst(rst), .addr(addr), .data(data), .wen(wen),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .error_num(err_o), .duration(dur_o), .checked(chk_o), .finish(fin_o), .timed_out(to_o));

  typedef struct packed {
    logic [7:0]  err;
    logic [3:0]  chk;
    logic [15:0] dur;
    logic        to;
  } res_t;

  int checks = 0;
  int failures = 0;
  int exp_n = 0;
  int seen_u = 0;
  int seen_o = 0;
  logic pf_u = 1'b0;
  logic pf_o = 1'b0;
  res_t q_u[$];
  res_t q_o[$];

  bit m_valid [NC];
  int m_addr  [NC];
  int m_data  [NC];
  int w_addr[$], w_data[$], w_h[$], w_g[$], w_k[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Reference: walk accepted writes by CHECK-cycle index d = k-1, stop at completion or timeout
  function automatic res_t model(input bit ordered);
    res_t r;
    int   en[$];
    bit   used [NC];
    int   chk, err, dur, d, slot;
    bit   done, known;
    chk = 0; err = 0; dur = 0;
    for (int i = 0; i < NC; i++) begin
      used[i] = 1'b0;
      if (m_valid[i]) en.push_back(i);
    end
    done = (en.size() == 0);
    r.to = 1'b0;
    for (int j = 0; j < w_k.size() && !done; j++) begin
      d = w_k[j] - 1;
      if (d >= int'(TO) - 1) break;
      known = 1'b0;
      slot  = -1;
      for (int x = 0; x < en.size(); x++) begin
        if (m_addr[en[x]] == w_addr[j]) begin
          known = 1'b1;
          if (!used[en[x]] && slot < 0) slot = en[x];
        end
      end
      if (ordered) begin
        if (known) begin
          if (m_addr[en[chk]] != w_addr[j] || m_data[en[chk]] != w_data[j]) err++;
          chk++;
        end
      end else if (slot >= 0) begin
        used[slot] = 1'b1;
        chk++;
        if (m_data[slot] != w_data[j]) err++;
      end else if (known) begin
        err++;
      end
      if (chk == en.size()) begin
        done = 1'b1;
        dur  = d + 1;
      end
    end
    if (!done) begin
      dur  = int'(TO) - 1;
      r.to = 1'b1;
      err  = err + en.size() - chk;
    end
    if (err > 254) err = 254;
    r.err = 8'(err);
    r.chk = 4'(chk);
    r.dur = 16'(dur);
    return r;
  endfunction

  always @(negedge clk) begin
    res_t e;
    if (fin_u && !pf_u) begin
      if (q_u.size() == 0) begin
        check("u_unexpected_finish", 1, 0);
      end else begin
        e = q_u.pop_front();
        check("u_error_num", int'(err_u), int'(e.err));
        check("u_checked",   int'(chk_u), int'(e.chk));
        check("u_duration",  int'(dur_u), int'(e.dur));
        check("u_timed_out", int'(to_u),  int'(e.to));
      end
      seen_u++;
    end
    pf_u = fin_u;
  end

  always @(negedge clk) begin
    res_t e;
    if (fin_o && !pf_o) begin
      if (q_o.size() == 0) begin
        check("o_unexpected_finish", 1, 0);
      end else begin
        e = q_o.pop_front();
        check("o_error_num", int'(err_o), int'(e.err));
        check("o_checked",   int'(chk_o), int'(e.chk));
        check("o_duration",  int'(dur_o), int'(e.dur));
        check("o_timed_out", int'(to_o),  int'(e.to));
      end
      seen_o++;
    end
    pf_o = fin_o;
  end

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b0; wen = 1'b0; cfg_we = 1'b0;
    for (int i = 0; i < NC; i++) m_valid[i] = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic prog(input int idx, input int a, input int d);
    @(negedge clk);
    cfg_we = 1'b1; cfg_idx = 3'(idx); cfg_addr = AW'(a); cfg_data = DW'(d);
    m_valid[idx] = 1'b1; m_addr[idx] = a; m_data[idx] = d;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic add_w(input int a, input int d, input int h, input int g);
    w_addr.push_back(a); w_data.push_back(d); w_h.push_back(h); w_g.push_back(g);
  endtask

  task automatic arm();
    @(negedge clk);
    wen = 1'b1; addr = '0; data = DW'(5);
    @(negedge clk);
    wen = 1'b0;
  endtask

  task automatic run_case();
    int nxt;
    bool_wait: begin end
    nxt = 2;
    w_k.delete();
    for (int j = 0; j < w_addr.size(); j++) begin
      w_k.push_back(nxt + w_g[j]);
      nxt = nxt + w_g[j] + w_h[j] + 1;
    end
    q_u.push_back(model(1'b0));
    q_o.push_back(model(1'b1));
    exp_n++;
    arm();
    for (int j = 0; j < w_addr.size(); j++) begin
      repeat (w_g[j]) @(negedge clk);
      @(negedge clk);
      wen = 1'b1; addr = AW'(w_addr[j]); data = DW'(w_data[j]);
      repeat (w_h[j] - 1) @(negedge clk);
      @(negedge clk);
      wen = 1'b0;
    end
    for (int c = 0; c < 3 * int'(TO) + 20 && !(seen_u == exp_n && seen_o == exp_n); c++)
      @(negedge clk);
    if (!(seen_u == exp_n && seen_o == exp_n)) begin
      check("finish_wait", 0, 1);
      seen_u = exp_n; seen_o = exp_n;
      q_u.delete(); q_o.delete();
    end
    w_addr.delete(); w_data.delete(); w_h.delete(); w_g.delete(); w_k.delete();
  endtask

  task automatic std_table();
    prog(0, 1, 4); prog(1, 2, 4); prog(2, 3, 4);
  endtask

  initial begin
    reset_dut();
    @(negedge clk);
    check("rst_err_u", int'(err_u), 255);
    check("rst_err_o", int'(err_o), 255);
    check("rst_dur_u", int'(dur_u), 0);
    check("rst_chk_u", int'(chk_u), 0);
    check("rst_fin_u", int'(fin_u), 0);
    check("rst_to_u",  int'(to_u),  0);
    check("rst_fin_o", int'(fin_o), 0);

    // all matching, one held write with bad data, duplicate, out of order, timeout
    std_table(); add_w(1, 4, 1, 0); add_w(2, 4, 1, 0); add_w(3, 4, 1, 0); run_case();
    reset_dut();
    std_table(); add_w(1, 4, 1, 0); add_w(2, 7, 5, 0); add_w(3, 4, 1, 1); run_case();
    reset_dut();
    std_table(); add_w(3, 4, 1, 0); add_w(1, 4, 1, 0); add_w(1, 4, 1, 0); add_w(2, 4, 1, 0); run_case();
    reset_dut();
    std_table(); add_w(2, 4, 1, 0); add_w(1, 4, 1, 0); add_w(3, 4, 1, 0); run_case();
    reset_dut();
    std_table(); add_w(1, 4, 1, 0); run_case();

    // wrong start data ignored, then reset in the middle of CHECK
    reset_dut();
    std_table();
    @(negedge clk); wen = 1'b1; addr = '0; data = DW'(6);
    @(negedge clk); wen = 1'b0;
    @(negedge clk);
    check("bad_start_err_u", int'(err_u), 255);
    arm();
    check("armed_err_u", int'(err_u), 0);
    check("armed_err_o", int'(err_o), 0);
    @(negedge clk); wen = 1'b1; addr = AW'(1); data = DW'(4);
    @(negedge clk); wen = 1'b0;
    @(negedge clk);
    check("mid_chk_u", int'(chk_u), 1);
    check("mid_chk_o", int'(chk_o), 1);
    rst = 1'b0;
    #1;
    check("async_rst_err_u", int'(err_u), 255);
    check("async_rst_chk_u", int'(chk_u), 0);
    check("async_rst_dur_o", int'(dur_o), 0);
    for (int i = 0; i < NC; i++) m_valid[i] = 1'b0;
    @(negedge clk); rst = 1'b1;
    run_case();

    for (int t = 0; t < 25; t++) begin
      int n;
      reset_dut();
      for (int i = 0; i < NC; i++)
        if ($urandom_range(0, 1) == 1) prog(i, int'($urandom_range(1, 5)), int'($urandom_range(0, 2)));
      n = int'($urandom_range(0, 9));
      for (int j = 0; j < n; j++)
        add_w(int'($urandom_range(1, 6)), int'($urandom_range(0, 2)),
              ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 4)) : 1,
              int'($urandom_range(0, 1)));
      run_case();
    end

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
